// File: rtl/muu_dedup_pkg.sv
// -----------------------------------------------------------------------------
// muu_dedup_pkg
// Shared constants and types for the dedup line packer and hasher front end.
//   LANE_W  : width of one value word / line lane
//   LINE_W  : width of one packed line
//   LANES   : lanes per line
//   line_t  : one queued line, {last, data}
// -----------------------------------------------------------------------------
package muu_dedup_pkg;

    localparam int LANE_W = 64;
    localparam int LINE_W = 512;
    localparam int LANES  = 8;

    typedef struct packed {
        logic              last;
        logic [LINE_W-1:0] data;
    } line_t;

endpackage

// File: rtl/muu_dedup_pair_buf.sv
// -----------------------------------------------------------------------------
// muu_dedup_pair_buf
// Two-entry FIFO with an exposed occupancy count. Outputs present the head
// entry; data reads as zero and valid as low whenever the FIFO is empty or
// reset is asserted.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to enqueue
//   out_valid_o   : head entry valid
//   out_ready_i   : consumer accepts the head entry
//   out_data_o    : head entry
//   count_o       : number of stored entries, 0..2
// -----------------------------------------------------------------------------
module muu_dedup_pair_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [0:1];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign out_valid_o = !rst && (count_q != 2'd0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    assign do_pop  = out_valid_o && out_ready_i;
    assign do_push = push_i && (count_q != 2'd2);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only observable
    // once count_q covers it, and the output is masked to zero otherwise.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/muu_dedup_line_packer.sv
// -----------------------------------------------------------------------------
// muu_dedup_line_packer
// Packs a 64-bit value-word stream into 512-bit lines for the hasher bank.
// The final line of each value is zero-padded above its last word, and a
// saturating per-value word count is emitted on a separate meta channel.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready : value-word stream (1 word/cycle)
//   line_data/line_valid/line_last/line_ready : packed line output
//   meta_count/meta_valid/meta_ready  : words per completed value
// -----------------------------------------------------------------------------
module muu_dedup_line_packer
    import muu_dedup_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANE_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [LANES*LANE_W-1:0] line_data,
    output logic                    line_valid,
    output logic                    line_last,
    input  logic                    line_ready,
    output logic [CNT_BITS-1:0]     meta_count,
    output logic                    meta_valid,
    input  logic                    meta_ready
);

    localparam int                  PTR_W     = $clog2(LANES);
    localparam logic [PTR_W-1:0]    LAST_LANE = PTR_W'(LANES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    // Lanes 0..LANES-2 only; the top lane always comes straight from in_data.
    logic [LANE_W-1:0]   asm_q [0:LANES-2];
    logic [PTR_W-1:0]    lane_q, lane_d;
    logic [CNT_BITS-1:0] wcnt_q, wcnt_d;
    logic [CNT_BITS-1:0] wcnt_inc;

    logic  accept;
    logic  complete;
    line_t line_push;
    line_t line_head;
    logic [1:0] line_cnt;
    logic [1:0] meta_cnt;

    // Both buffers keep a free slot whenever a word is accepted, so a
    // completing word can always push without overflow. Only registered
    // counts feed this; the downstream ready signals never do.
    assign in_ready = !rst && (line_cnt != 2'd2) && (meta_cnt != 2'd2);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((lane_q == LAST_LANE) || in_last);
    assign wcnt_inc = (wcnt_q == CNT_MAX) ? CNT_MAX : wcnt_q + 1'b1;

    // Line assembly: lanes below lane_q from the assembly register, lane_q
    // from the incoming word, everything above zero. This zero-fill is what
    // hides stale lanes left over from earlier values.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        line_push      = '0;
        line_push.last = in_last;
        for (int i = 0; i < LANES - 1; i++) begin
            if (PTR_W'(i) < lane_q) line_push.data[i*LANE_W +: LANE_W] = asm_q[i];
        end
        line_push.data[lane_q*LANE_W +: LANE_W] = in_data;
    end

    // Word counter keeps running across lines of one value and clears only
    // once the value's last word has been counted.
    always_comb begin
        lane_d = lane_q;
        wcnt_d = wcnt_q;
        if (complete) begin
            lane_d = '0;
            wcnt_d = in_last ? '0 : wcnt_inc;
        end else if (accept) begin
            lane_d = lane_q + 1'b1;
            wcnt_d = wcnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            wcnt_q <= '0;
        end else begin
            lane_q <= lane_d;
            wcnt_q <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES - 1; i++) begin
            if (accept && !complete && (lane_q == PTR_W'(i))) asm_q[i] <= in_data;
        end
    end

    muu_dedup_pair_buf #(
        .WIDTH($bits(line_t))
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (complete),
        .push_data_i(line_push),
        .out_valid_o(line_valid),
        .out_ready_i(line_ready),
        .out_data_o (line_head),
        .count_o    (line_cnt)
    );

    muu_dedup_pair_buf #(
        .WIDTH(CNT_BITS)
    ) u_meta_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (complete && in_last),
        .push_data_i(wcnt_inc),
        .out_valid_o(meta_valid),
        .out_ready_i(meta_ready),
        .out_data_o (meta_count),
        .count_o    (meta_cnt)
    );

    assign line_data = line_head.data;
    assign line_last = line_head.last;

endmodule

// File: tb/tb_muu_dedup_line_packer.sv
// -----------------------------------------------------------------------------
// tb_muu_dedup_line_packer
// Scoreboard bench: a value-level model turns accepted words into expected
// lines and counts; independent monitors compare each DUT handshake.
// -----------------------------------------------------------------------------
module tb_muu_dedup_line_packer;

    localparam int CNT_BITS = 16;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [63:0]         in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [511:0]        line_data;
    logic                line_valid;
    logic                line_last;
    logic                line_ready;
    logic [CNT_BITS-1:0] meta_count;
    logic                meta_valid;
    logic                meta_ready;

    muu_dedup_line_packer #(
        .LANES   (8),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .line_data (line_data),
        .line_valid(line_valid),
        .line_last (line_last),
        .line_ready(line_ready),
        .meta_count(meta_count),
        .meta_valid(meta_valid),
        .meta_ready(meta_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_accepted = 0;
    bit drv_busy = 1'b0;
    bit rand_ready = 1'b0;

    // Reference model state: words of the current line-in-progress and the
    // word count of the current value; expected outputs in arrival order.
    logic [63:0]         chunk[$];
    int unsigned         vcount = 0;
    logic [512:0]        exp_lines[$];
    logic [CNT_BITS-1:0] exp_meta[$];

    bit           line_hold_v = 1'b0;
    logic [512:0] line_hold;
    bit           meta_hold_v = 1'b0;
    logic [CNT_BITS-1:0] meta_hold;

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_accept(input logic [63:0] w, input logic last);
        logic [511:0] data;
        chunk.push_back(w);
        vcount++;
        if (chunk.size() == 8 || last) begin
            data = '0;
            foreach (chunk[i]) data[64*i +: 64] = chunk[i];
            exp_lines.push_back({last, data});
            chunk.delete();
            if (last) begin
                exp_meta.push_back((vcount > CNT_MAX) ? CNT_BITS'(CNT_MAX) : CNT_BITS'(vcount));
                vcount = 0;
            end
        end
    endfunction

    // Monitor: all sampling happens on the falling edge, half a cycle away
    // from the edge on which the DUT updates and the bench drives.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_line_valid", line_valid, 0);
            check("rst_meta_valid", meta_valid, 0);
            check("rst_line_out", {line_last, line_data}, 0);
            check("rst_meta_count", meta_count, 0);
            chunk.delete();
            vcount = 0;
            exp_lines.delete();
            exp_meta.delete();
            line_hold_v = 1'b0;
            meta_hold_v = 1'b0;
        end else begin
            if (line_hold_v) check("line_stable", {line_valid, line_last, line_data}, {1'b1, line_hold});
            if (meta_hold_v) check("meta_stable", {meta_valid, meta_count}, {1'b1, meta_hold});

            if (in_valid && in_ready) begin
                n_accepted++;
                model_accept(in_data, in_last);
            end

            if (line_valid && line_ready) begin
                if (exp_lines.size() == 0) begin
                    check("line_spurious", line_valid, 0);
                end else begin
                    logic [512:0] e;
                    e = exp_lines.pop_front();
                    check("line_data", line_data, e[511:0]);
                    check("line_last", line_last, e[512]);
                end
            end

            if (meta_valid && meta_ready) begin
                if (exp_meta.size() == 0) begin
                    check("meta_spurious", meta_valid, 0);
                end else begin
                    check("meta_count", meta_count, exp_meta.pop_front());
                end
            end

            line_hold_v = line_valid && !line_ready;
            line_hold   = {line_last, line_data};
            meta_hold_v = meta_valid && !meta_ready;
            meta_hold   = meta_count;
        end
    end

    // Random backpressure, active only during the randomized phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            line_ready = ($urandom_range(0, 3) != 0);
            meta_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Drivers are entered and left 1 time unit after a rising edge.
    task automatic send_word(input logic [63:0] d, input logic last, input bit gaps);
        bit acc;
        int k;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc = 1'b0;
        for (k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("in_accept_timeout", acc, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_value(input int n, input logic [63:0] base, input bit gaps);
        drv_busy = 1'b1;
        for (int i = 0; i < n; i++) send_word(base + 64'(i), (i == n - 1), gaps);
        drv_busy = 1'b0;
    endtask

    task automatic wait_driver();
        for (int k = 0; k < 3000 && drv_busy; k++) begin
            @(posedge clk);
            #1;
        end
        check("driver_done", drv_busy, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && (exp_lines.size() + exp_meta.size()) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_lines.size() + exp_meta.size(), 0);
    endtask

    initial begin
        int base_acc;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        line_ready = 1'b1;
        meta_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // One full value of exactly one line; check the one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            send_word(64'(i), (i == 7), 1'b0);
            if (i == 6) check("lat_line_not_early", line_valid, 0);
        end
        check("lat_line_valid", line_valid, 1);
        check("lat_meta_valid", meta_valid, 1);
        drain();

        // Short value followed by a one-word value: stale lanes must be zero.
        send_word(64'hA, 1'b0, 1'b0);
        send_word(64'hB, 1'b0, 1'b0);
        send_word(64'hC, 1'b1, 1'b0);
        send_word(64'hD, 1'b1, 1'b0);
        drain();

        // Multi-line value with a partial final line.
        send_value(20, 64'h100, 1'b0);
        drain();

        // Line backpressure: exactly two lines queue, then input stalls.
        line_ready = 1'b0;
        base_acc   = n_accepted;
        fork
            send_value(24, 64'h200, 1'b0);
        join_none
        repeat (40) @(posedge clk);
        #1;
        check("line_stall_accepted", n_accepted - base_acc, 16);
        check("line_stall_in_ready", in_ready, 0);
        check("line_stall_valid", line_valid, 1);
        line_ready = 1'b1;
        wait_driver();
        drain();

        // Meta backpressure: two one-word values fill the meta buffer.
        meta_ready = 1'b0;
        base_acc   = n_accepted;
        fork
            begin
                drv_busy = 1'b1;
                for (int v = 0; v < 5; v++) send_word(64'h300 + 64'(v), 1'b1, 1'b0);
                drv_busy = 1'b0;
            end
        join_none
        repeat (30) @(posedge clk);
        #1;
        check("meta_stall_accepted", n_accepted - base_acc, 2);
        check("meta_stall_in_ready", in_ready, 0);
        meta_ready = 1'b1;
        wait_driver();
        drain();

        // Reset in the middle of a value discards everything in flight.
        for (int i = 0; i < 5; i++) send_word(64'h500 + 64'(i), 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_line_valid", line_valid, 0);
        check("post_rst_meta_valid", meta_valid, 0);
        send_value(3, 64'h600, 1'b0);
        drain();

        // Randomized lengths, data, input gaps and backpressure.
        rand_ready = 1'b1;
        for (int v = 0; v < 150; v++) begin
            int n;
            n = $urandom_range(1, 20);
            drv_busy = 1'b1;
            for (int i = 0; i < n; i++) send_word({$urandom, $urandom}, (i == n - 1), 1'b1);
            drv_busy = 1'b0;
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        line_ready = 1'b1;
        meta_ready = 1'b1;
        drain();

        // Long value: the word count saturates.
        send_value(70000, 64'h1_0000_0000, 1'b0);
        drain();

        check("final_lines_empty", exp_lines.size(), 0);
        check("final_meta_empty", exp_meta.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
